exec_seq_ctrl: RTL and testbench
================================

// Module: exec_seq_ctrl
// PURPOSE
//   Multi-cycle sequencer for the RV64 core datapath: IFU memory, decoder, RegisterFile, Alu, PC.
//   Moore FSM with the steps IF -> ID -> EX -> [MEM] -> WB.
//   Drives the instruction-fetch and data-memory req/ack handshakes.
//   Emits one-cycle enables: instruction latch, regfile write, PC update.
//   Ends execution on ebreak (HALT), unimplemented instruction (TRAP) or memory timeout (ERR).
//   Instantiated in top, replacing the free-running always-enabled regfile/PC write.
// PARAMETERS
//   TIMEOUT_CYCLES  256  max wait cycles for an ack in IF/MEM; 0 = no timeout
//   TO_W            16   width of the timeout counter; TIMEOUT_CYCLES < 2**TO_W
// PORTS
//   clk           in   1   clock, all state on posedge
//   rst           in   1   synchronous, active-high reset
//   imem_req      out  1   instruction fetch request
//   imem_ack      in   1   fetch data valid this cycle
//   ir_wen        out  1   latch instruction register
//   inst_not_ipl  in   1   decoder: unimplemented instruction
//   is_ebreak     in   1   decoder: ebreak
//   is_mem        in   1   decoder: load/store
//   dmem_req      out  1   data memory request
//   dmem_ack      in   1   data access complete
//   reg_wen       out  1   RegisterFile write enable
//   pc_wen        out  1   PC advance enable
//   halted        out  1   sticky, ebreak reached
//   trap          out  1   sticky, illegal instruction or timeout
//   state         out  3   FSM state, for debug
//   cycle_cnt     out  64  active cycles (PERF_CNT_EN)
//   instret_cnt   out  64  retired instructions (PERF_CNT_EN)
// BEHAVIOUR
//   State encoding: IF=0 ID=1 EX=2 MEM=3 WB=4 HALT=5 TRAP=6 ERR=7.
//   rst=1 at posedge: state<=IF, timeout cnt<=0, counters<=0.
//     All outputs 0 during reset except imem_req, which is 1 from the first cycle in IF.
//   IF:   imem_req=1; ir_wen=imem_ack; imem_ack -> ID.
//   ID:   inst_not_ipl -> TRAP, else EX.
//   EX:   is_ebreak -> HALT (no WB, no pc_wen); else is_mem -> MEM; else WB.
//   MEM:  dmem_req=1; dmem_ack -> WB.
//   WB:   reg_wen=1, pc_wen=1 for exactly 1 cycle; -> IF.
//   HALT: halted=1. TRAP/ERR: trap=1. All three are terminal until rst.
//         No req or enable is asserted in a terminal state.
//   Handshake:
//     - req is held high while waiting; transfer completes on the cycle ack=1 with req=1.
//     - ack while req=0 is ignored.
//     - ack may arrive in the first req cycle (0-wait).
//   Latency, 0-wait acks: ALU op = 4 cycles (IF,ID,EX,WB); load/store = 5 cycles.
//   Timeout:
//     - Counter clears on entry to IF/MEM and increments each waiting cycle without ack.
//     - If TIMEOUT_CYCLES!=0 and the counter == TIMEOUT_CYCLES-1 with no ack -> ERR next cycle.
//     - Ack in that same cycle wins: normal transition, no ERR.
//   Decoder flags are sampled only in ID/EX; their values in other states are don't-care.
//   Reset mid-transaction (any state):
//     - Outstanding req drops; no reg_wen/pc_wen is issued.
//     - Next cycle is IF with a fresh fetch.
//   reg_wen and pc_wen are always coincident; neither is ever high outside WB.
// CONFIGURATION
//   PERF_CNT_EN defined:
//     - cycle_cnt +1 each cycle state is in {IF,ID,EX,MEM,WB}.
//     - instret_cnt +1 each WB cycle.
//     - Both 64-bit, wrap modulo 2**64, cleared by rst.
//   PERF_CNT_EN undefined: cycle_cnt and instret_cnt tied to 0; ports remain.
// TESTING
//   1. rst 2 cycles, ack always 1, ALU insts -> reg_wen/pc_wen pulse every 4th cycle;
//      state seq 0,1,2,4 repeating.
//   2. is_mem=1, dmem_ack delayed 3 cycles -> MEM lasts 4 cycles; WB pulse at cycle 8 from IF entry.
//   3. is_ebreak=1 in EX -> state=5, halted=1 permanently, no pc_wen;
//      rst -> state=0, halted=0.
//   4. inst_not_ipl=1 in ID -> state=6, trap=1, no reg_wen ever after.
//   5. TIMEOUT_CYCLES=4, imem_ack=0 -> ERR after 4 IF cycles;
//      repeat with ack on 4th cycle -> ID, no ERR.
//   6. PERF_CNT_EN, 10 ALU insts at 0-wait -> instret_cnt=10, cycle_cnt=40;
//      rst mid-MEM -> counters 0, no WB pulse.

Source files
------------

// File: rtl/exec_seq_ctrl.sv
// Multi-cycle IF/ID/EX/MEM/WB sequencer with fetch/data handshakes and ack timeout.
// Optional performance counters are built when PERF_CNT_EN is defined.
module exec_seq_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned TO_W           = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  input  logic        imem_ack,
  output logic        ir_wen,
  input  logic        inst_not_ipl,
  input  logic        is_ebreak,
  input  logic        is_mem,
  output logic        dmem_req,
  input  logic        dmem_ack,
  output logic        reg_wen,
  output logic        pc_wen,
  output logic        halted,
  output logic        trap,
  output logic [2:0]  state,
  output logic [63:0] cycle_cnt,
  output logic [63:0] instret_cnt
);

  localparam logic [2:0] StIf   = 3'd0;
  localparam logic [2:0] StId   = 3'd1;
  localparam logic [2:0] StEx   = 3'd2;
  localparam logic [2:0] StMem  = 3'd3;
  localparam logic [2:0] StWb   = 3'd4;
  localparam logic [2:0] StHalt = 3'd5;
  localparam logic [2:0] StTrap = 3'd6;
  localparam logic [2:0] StErr  = 3'd7;

  localparam bit             ToEn   = (TIMEOUT_CYCLES != 0);
  localparam logic [TO_W-1:0] ToLast = TO_W'(TIMEOUT_CYCLES - 1);

  logic [2:0]      state_q, state_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            to_hit;

  assign to_hit = ToEn && (to_cnt_q == ToLast);

  always_comb begin
    state_d  = state_q;
    to_cnt_d = to_cnt_q;
    case (state_q)
      StIf: begin
        if (imem_ack)    state_d = StId;
        else if (to_hit) state_d = StErr;
        else             to_cnt_d = to_cnt_q + TO_W'(1);
      end
      StId: state_d = inst_not_ipl ? StTrap : StEx;
      StEx: begin
        if (is_ebreak) begin
          state_d = StHalt;
        end else if (is_mem) begin
          state_d  = StMem;
          to_cnt_d = '0;
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        if (dmem_ack)    state_d = StWb;
        else if (to_hit) state_d = StErr;
        else             to_cnt_d = to_cnt_q + TO_W'(1);
      end
      StWb: begin
        state_d  = StIf;
        to_cnt_d = '0;
      end
      default: ;  // HALT/TRAP/ERR hold until reset
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIf;
      to_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      to_cnt_q <= to_cnt_d;
    end
  end

  // Everything but the fetch request is forced low while reset is held.
  assign imem_req = (state_q == StIf);
  assign ir_wen   = !rst && (state_q == StIf) && imem_ack;
  assign dmem_req = !rst && (state_q == StMem);
  assign reg_wen  = !rst && (state_q == StWb);
  assign pc_wen   = !rst && (state_q == StWb);
  assign halted   = !rst && (state_q == StHalt);
  assign trap     = !rst && ((state_q == StTrap) || (state_q == StErr));
  assign state    = rst ? StIf : state_q;

`ifdef PERF_CNT_EN
  logic [63:0] cyc_q, ret_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else begin
      if (state_q <= StWb) cyc_q <= cyc_q + 64'd1;
      if (state_q == StWb) ret_q <= ret_q + 64'd1;
    end
  end

  assign cycle_cnt   = rst ? '0 : cyc_q;
  assign instret_cnt = rst ? '0 : ret_q;
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_exec_seq_ctrl.sv
// Bench for exec_seq_ctrl: reset/ebreak/trap vector table, then randomized instruction
// streams checked against a per-instruction timeline model, plus counter and reset corners.
module tb_exec_seq_ctrl;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req, imem_ack = 1'b0, ir_wen;
  logic        inst_not_ipl = 1'b0, is_ebreak = 1'b0, is_mem = 1'b0;
  logic        dmem_req, dmem_ack = 1'b0;
  logic        reg_wen, pc_wen, halted, trap;
  logic [2:0]  state;
  logic [63:0] cycle_cnt, instret_cnt;

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] ecyc = '0;
  logic [63:0] eret = '0;

  exec_seq_ctrl #(.TIMEOUT_CYCLES(TO), .TO_W(16)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_ack(imem_ack), .ir_wen(ir_wen),
    .inst_not_ipl(inst_not_ipl), .is_ebreak(is_ebreak), .is_mem(is_mem),
    .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .reg_wen(reg_wen), .pc_wen(pc_wen), .halted(halted), .trap(trap),
    .state(state), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  always #5 clk = ~clk;

  // {state, imem_req, ir_wen, dmem_req, reg_wen, pc_wen, halted, trap}
  function automatic logic [9:0] mk(input int st, input bit ireq, input bit irw,
                                    input bit dreq, input bit wen, input bit hlt,
                                    input bit trp);
    logic [2:0] s;
    s = st[2:0];
    return {s, ireq, irw, dreq, wen, wen, hlt, trp};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic check64(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // One clock cycle: drive at negedge, compare outputs, then advance the counter model.
  task automatic step(input logic r, input logic ia, input logic da, input logic ni,
                      input logic eb, input logic me, input bit chk,
                      input logic [9:0] exp, input string nm);
    logic [9:0] got;
    @(negedge clk);
    rst = r; imem_ack = ia; dmem_ack = da;
    inst_not_ipl = ni; is_ebreak = eb; is_mem = me;
    #1;
    got = {state, imem_req, ir_wen, dmem_req, reg_wen, pc_wen, halted, trap};
    if (chk) begin
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL %s: got st=%0d ireq/irw/dreq/rw/pw/h/t=%b expected st=%0d %b",
                 nm, got[9:7], got[6:0], exp[9:7], exp[6:0]);
      end
`ifdef PERF_CNT_EN
      check64({nm, " cycle_cnt"}, cycle_cnt, r ? 64'd0 : ecyc);
      check64({nm, " instret_cnt"}, instret_cnt, r ? 64'd0 : eret);
`else
      check64({nm, " cycle_cnt"}, cycle_cnt, 64'd0);
      check64({nm, " instret_cnt"}, instret_cnt, 64'd0);
`endif
    end
    if (r) begin
      ecyc = '0;
      eret = '0;
    end else begin
      if (exp[9:7] <= 3'd4) ecyc = ecyc + 64'd1;
      if (exp[9:7] == 3'd4) eret = eret + 64'd1;
    end
  endtask

  task automatic terminal(input int st);
    for (int i = 0; i < 3; i++)
      step(0, rb(), rb(), rb(), rb(), rb(), 1, mk(st, 0, 0, 0, 0, st == 5, st >= 6), "terminal");
    step(1, rb(), rb(), rb(), rb(), rb(), 1, mk(0, 0, 0, 0, 0, 0, 0), "terminal_rst");
  endtask

  // kind: 0 ALU, 1 load/store, 2 ebreak, 3 illegal. di/dm: ack wait cycles (>=TO times out).
  task automatic run_inst(input int kind, input int di, input int dm);
    for (int k = 0; ; k++) begin
      logic a;
      a = (k == di);
      step(0, a, rb(), rb(), rb(), rb(), 1, mk(0, 1, a, 0, 0, 0, 0), "fetch");
      if (a) break;
      if (k == int'(TO) - 1) begin
        terminal(7);
        return;
      end
    end
    step(0, rb(), rb(), kind == 3, rb(), rb(), 1, mk(1, 0, 0, 0, 0, 0, 0), "decode");
    if (kind == 3) begin
      terminal(6);
      return;
    end
    step(0, rb(), rb(), rb(), kind == 2, (kind == 1) || (kind == 2 && rb()), 1,
         mk(2, 0, 0, 0, 0, 0, 0), "execute");
    if (kind == 2) begin
      terminal(5);
      return;
    end
    if (kind == 1) begin
      for (int k = 0; ; k++) begin
        logic a;
        a = (k == dm);
        step(0, rb(), a, rb(), rb(), rb(), 1, mk(3, 0, 0, 1, 0, 0, 0), "mem");
        if (a) break;
        if (k == int'(TO) - 1) begin
          terminal(7);
          return;
        end
      end
    end
    step(0, rb(), rb(), rb(), rb(), rb(), 1, mk(4, 0, 0, 0, 1, 0, 0), "writeback");
  endtask

  typedef struct {
    logic r, ia, da, ni, eb, me;
    bit   chk;
    logic [9:0] exp;
  } vec_t;

  vec_t tbl[26];

  initial begin
    tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, '0};
    tbl[1]  = '{1, 1, 0, 0, 0, 0, 1, mk(0, 1, 0, 0, 0, 0, 0)};
    tbl[2]  = '{0, 1, 0, 0, 0, 0, 1, mk(0, 1, 1, 0, 0, 0, 0)};
    tbl[3]  = '{0, 0, 1, 0, 1, 1, 1, mk(1, 0, 0, 0, 0, 0, 0)};
    tbl[4]  = '{0, 0, 0, 0, 0, 0, 1, mk(2, 0, 0, 0, 0, 0, 0)};
    tbl[5]  = '{0, 1, 1, 1, 1, 1, 1, mk(4, 0, 0, 0, 1, 0, 0)};
    tbl[6]  = '{0, 1, 0, 0, 0, 0, 1, mk(0, 1, 1, 0, 0, 0, 0)};
    tbl[7]  = '{0, 0, 0, 0, 0, 0, 1, mk(1, 0, 0, 0, 0, 0, 0)};
    tbl[8]  = '{0, 0, 0, 0, 0, 1, 1, mk(2, 0, 0, 0, 0, 0, 0)};
    tbl[9]  = '{0, 0, 1, 0, 0, 0, 1, mk(3, 0, 0, 1, 0, 0, 0)};
    tbl[10] = '{0, 0, 0, 0, 0, 0, 1, mk(4, 0, 0, 0, 1, 0, 0)};
    tbl[11] = '{0, 0, 0, 0, 0, 0, 1, mk(0, 1, 0, 0, 0, 0, 0)};
    tbl[12] = '{0, 1, 0, 0, 0, 0, 1, mk(0, 1, 1, 0, 0, 0, 0)};
    tbl[13] = '{0, 0, 0, 0, 0, 0, 1, mk(1, 0, 0, 0, 0, 0, 0)};
    tbl[14] = '{0, 0, 0, 0, 1, 1, 1, mk(2, 0, 0, 0, 0, 0, 0)};
    tbl[15] = '{0, 1, 1, 1, 1, 1, 1, mk(5, 0, 0, 0, 0, 1, 0)};
    tbl[16] = '{0, 0, 0, 0, 0, 0, 1, mk(5, 0, 0, 0, 0, 1, 0)};
    tbl[17] = '{1, 1, 1, 0, 0, 0, 1, mk(0, 0, 0, 0, 0, 0, 0)};
    tbl[18] = '{0, 0, 0, 0, 0, 0, 1, mk(0, 1, 0, 0, 0, 0, 0)};
    tbl[19] = '{0, 1, 0, 0, 0, 0, 1, mk(0, 1, 1, 0, 0, 0, 0)};
    tbl[20] = '{0, 0, 0, 1, 0, 0, 1, mk(1, 0, 0, 0, 0, 0, 0)};
    tbl[21] = '{0, 1, 1, 1, 1, 1, 1, mk(6, 0, 0, 0, 0, 0, 1)};
    tbl[22] = '{0, 0, 0, 0, 0, 0, 1, mk(6, 0, 0, 0, 0, 0, 1)};
    tbl[23] = '{1, 0, 0, 0, 0, 0, 1, mk(0, 0, 0, 0, 0, 0, 0)};
    tbl[24] = '{0, 0, 0, 0, 0, 0, 1, mk(0, 1, 0, 0, 0, 0, 0)};
    tbl[25] = '{1, 0, 0, 0, 0, 0, 1, mk(0, 1, 0, 0, 0, 0, 0)};

    for (int i = 0; i < 26; i++)
      step(tbl[i].r, tbl[i].ia, tbl[i].da, tbl[i].ni, tbl[i].eb, tbl[i].me,
           tbl[i].chk, tbl[i].exp, $sformatf("table[%0d]", i));

    // Delayed data ack: MEM spans 4 cycles, WB on cycle 8 after IF entry.
    run_inst(1, 0, 3);
    // Fetch timeout, then ack on the last allowed wait cycle.
    run_inst(0, 4, 0);
    run_inst(0, 3, 0);
    run_inst(1, 0, 4);
    run_inst(1, 2, 3);

    // Ten zero-wait ALU instructions straight out of reset.
    step(1, 0, 0, 0, 0, 0, 1, mk(0, 1, 0, 0, 0, 0, 0), "perf_rst");
    for (int i = 0; i < 10; i++) run_inst(0, 0, 0);
    @(posedge clk);
    #1;
`ifdef PERF_CNT_EN
    check64("perf cycle_cnt after 10", cycle_cnt, 64'd40);
    check64("perf instret_cnt after 10", instret_cnt, 64'd10);
`else
    check64("perf cycle_cnt after 10", cycle_cnt, 64'd0);
    check64("perf instret_cnt after 10", instret_cnt, 64'd0);
`endif

    // Reset while a data access is outstanding: request drops, no WB pulse.
    step(0, 1, 0, 0, 0, 0, 1, mk(0, 1, 1, 0, 0, 0, 0), "midmem fetch");
    step(0, 0, 0, 0, 0, 1, 1, mk(1, 0, 0, 0, 0, 0, 0), "midmem decode");
    step(0, 0, 0, 0, 0, 1, 1, mk(2, 0, 0, 0, 0, 0, 0), "midmem execute");
    step(0, 0, 0, 0, 0, 0, 1, mk(3, 0, 0, 1, 0, 0, 0), "midmem wait");
    step(1, 0, 1, 0, 0, 0, 1, mk(0, 0, 0, 0, 0, 0, 0), "midmem rst");
    step(0, 0, 1, 0, 0, 0, 1, mk(0, 1, 0, 0, 0, 0, 0), "midmem refetch");
    step(1, 0, 0, 0, 0, 0, 1, mk(0, 1, 0, 0, 0, 0, 0), "midmem rst2");

    for (int i = 0; i < 60; i++) begin
      int sel, kind;
      sel  = $urandom_range(0, 9);
      kind = (sel < 5) ? 0 : (sel < 8) ? 1 : (sel == 8) ? 2 : 3;
      run_inst(kind, $urandom_range(0, 5), $urandom_range(0, 5));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
